// File: rtl/input_sync_pkg.sv
// Shared helpers for the input conditioning path.
package input_sync_pkg;

    // Map a raw pin level to the logical level, where 1 always means asserted.
    function automatic logic to_logical(input logic raw, input logic active_low);
        return raw ^ active_low;
    endfunction

endpackage

// File: rtl/input_sync.sv
// Single-bit input conditioner: polarity fix-up, two-flop synchronizer and
// an enable-gated rising-edge detector that emits a one-clock event pulse.
module input_sync
    import input_sync_pkg::*;
#(
    parameter logic inv = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic signal_in,
    output logic signal_out
);

    logic w_lvl;
    logic r_s1;
    logic r_s2;
    logic r_prev;
    logic r_out;

    assign w_lvl      = to_logical(signal_in, inv);
    assign signal_out = r_out;

    // Synchronize every cycle; edge-detect and pulse only on sample-enable cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_prev <= 1'b0;
            r_out  <= 1'b0;
        end else begin
            r_s1 <= w_lvl;
            r_s2 <= r_s1;
            if (enable) begin
                r_prev <= r_s2;
                r_out  <= r_s2 & ~r_prev;
            end else begin
                r_out  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_input_sync.sv
// Self-checking bench for input_sync: one active-low (button) instance and
// one active-high (data line) instance, compared every cycle against a
// level-history reference model, plus directed scenarios with literal pins.
module tb_input_sync;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en_level = 1'b1;
    logic       strobe_mode = 1'b0;
    logic       sig_a = 1'b1;
    logic       sig_b = 1'b0;
    logic       out_a;
    logic       out_b;
    logic [2:0] r_phase = '0;
    logic       en;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Strobe generator: one enable cycle every 8 clocks when strobe_mode is set.
    always @(posedge clk) r_phase <= r_phase + 3'd1;
    assign en = strobe_mode ? (r_phase == 3'd0) : en_level;

    input_sync #(.inv(1'b1)) u_btn (
        .clk(clk), .rst(rst), .enable(en), .signal_in(sig_a), .signal_out(out_a)
    );
    input_sync #(.inv(1'b0)) u_data (
        .clk(clk), .rst(rst), .enable(en), .signal_in(sig_b), .signal_out(out_b)
    );

    // ---------------- reference model ----------------
    // The level seen by the edge stage at clock edge n is the logical input
    // level captured two edges earlier. A pulse is due at an enabled edge when
    // that level is 1 and the level seen at the previous enabled edge was 0.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit hist [2][3];
    bit last_seen [2];
    bit exp_o [2];
    int pulses [2];
    int pulse_cyc [2][$];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int ch = 0; ch < 2; ch++) begin
                for (int i = 0; i < 3; i++) hist[ch][i] = 1'b0;
                last_seen[ch] = 1'b0;
                exp_o[ch]     = 1'b0;
            end
        end else begin
            bit lvl_in [2];
            bit seen;
            lvl_in[0] = ~sig_a;
            lvl_in[1] = sig_b;
            for (int ch = 0; ch < 2; ch++) begin
                hist[ch][2] = hist[ch][1];
                hist[ch][1] = hist[ch][0];
                hist[ch][0] = lvl_in[ch];
                seen = hist[ch][2];
                exp_o[ch] = en && seen && !last_seen[ch];
                if (en) last_seen[ch] = seen;
                if (exp_o[ch]) begin
                    pulses[ch]++;
                    pulse_cyc[ch].push_back(cyc + 1);
                end
            end
        end
    end

    // Every-cycle comparison, sampled away from the active edge.
    always @(negedge clk) begin
        total++;
        if (out_a !== exp_o[0]) begin
            bad++;
            $display("FAIL btn_out cyc=%0d got=%b want=%b", cyc, out_a, exp_o[0]);
        end
        total++;
        if (out_b !== exp_o[1]) begin
            bad++;
            $display("FAIL data_out cyc=%0d got=%b want=%b", cyc, out_b, exp_o[1]);
        end
    end

    task automatic check(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, want);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    int p0;
    int p1;
    int c0;
    int guard;

    initial begin
        // Reset with idle button (signal_in=1) held through reset.
        rst = 1'b0;
        clk_n(3);
        check("out_in_reset", out_a, 0);
        rst = 1'b1;
        p0 = pulses[0];
        clk_n(10);
        check("idle_btn_no_pulse", pulses[0] - p0, 0);

        // Button press: exactly one pulse, 3 clocks after the change.
        p0 = pulses[0];
        c0 = cyc;
        sig_a = 1'b0;
        clk_n(10);
        check("press_one_pulse", pulses[0] - p0, 1);
        check("press_latency", pulse_cyc[0][pulse_cyc[0].size()-1] - c0, 3);
        p0 = pulses[0];
        sig_a = 1'b1;
        clk_n(6);
        check("release_no_pulse", pulses[0] - p0, 0);

        // Active-high data line: input pulses at cycles 0 and 2.
        p1 = pulses[1];
        c0 = cyc;
        sig_b = 1'b1; clk_n(1);
        sig_b = 1'b0; clk_n(1);
        sig_b = 1'b1; clk_n(1);
        sig_b = 1'b0; clk_n(8);
        check("data_two_pulses", pulses[1] - p1, 2);
        check("data_first_at_3", pulse_cyc[1][pulse_cyc[1].size()-2] - c0, 3);
        check("data_second_at_5", pulse_cyc[1][pulse_cyc[1].size()-1] - c0, 5);

        // Strobed enable every 8 clocks: held press gives one pulse.
        strobe_mode = 1'b1;
        clk_n(10);
        p0 = pulses[0];
        c0 = cyc;
        sig_a = 1'b0;
        clk_n(10);
        sig_a = 1'b1;
        clk_n(16);
        check("strobe_one_pulse", pulses[0] - p0, 1);
        check("strobe_latency_ok",
              (pulse_cyc[0][pulse_cyc[0].size()-1] - c0 >= 3) &&
              (pulse_cyc[0][pulse_cyc[0].size()-1] - c0 <= 10), 1);

        // Two-clock glitch placed just after a strobe: never seen, no pulse.
        guard = 0;
        while (r_phase != 3'd1 && guard < 16) begin
            clk_n(1);
            guard++;
        end
        check("phase_align", r_phase, 1);
        p0 = pulses[0];
        sig_a = 1'b0; clk_n(2);
        sig_a = 1'b1; clk_n(16);
        check("glitch_ignored", pulses[0] - p0, 0);

        // Enable held high: long hold gives one pulse, re-press gives another.
        strobe_mode = 1'b0;
        en_level    = 1'b1;
        p0 = pulses[0];
        sig_a = 1'b0; clk_n(20);
        check("hold_single_pulse", pulses[0] - p0, 1);
        sig_a = 1'b1; clk_n(4);
        sig_a = 1'b0; clk_n(10);
        check("repress_second_pulse", pulses[0] - p0, 2);
        sig_a = 1'b1; clk_n(6);

        // Reset asserted while the pulse is high.
        sig_a = 1'b0;
        clk_n(3);
        check("pulse_before_rst", out_a, 1);
        rst = 1'b0;
        #1;
        check("async_drop", out_a, 0);
        clk_n(2);
        rst = 1'b1;
        p0 = pulses[0];
        clk_n(8);
        check("fresh_pulse_after_rst", pulses[0] - p0, 1);
        sig_a = 1'b1;
        clk_n(4);

        // Randomized traffic, enable modes and occasional resets.
        for (int it = 0; it < 3000; it++) begin
            if ($urandom_range(99) == 0) strobe_mode = ~strobe_mode;
            en_level = ($urandom_range(3) != 0);
            if ($urandom_range(4) == 0) sig_a = ~sig_a;
            if ($urandom_range(3) == 0) sig_b = ~sig_b;
            if ($urandom_range(299) == 0) begin
                rst = 1'b0;
                clk_n($urandom_range(3, 1));
                rst = 1'b1;
            end
            clk_n(1);
        end
        check("random_saw_pulses", (pulses[0] > 10) && (pulses[1] > 10), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
